// File: rtl/gpio_stream_packer_pkg.sv
// Shared constants and FIFO entry layout for the GPIO byte-to-word packer.
package gpio_stream_packer_pkg;

   localparam int GPIO_BYTE_W   = 8;
   localparam int GPIO_LAST_BIT = 8;
   localparam int WORD_W        = 32;
   localparam int LANES         = WORD_W / GPIO_BYTE_W;
   localparam int NBYTES_W      = 3;

   typedef struct packed {
      logic                last;
      logic [NBYTES_W-1:0] nbytes;
      logic [WORD_W-1:0]   data;
   } fifo_entry_t;

   localparam int ENTRY_W = $bits(fifo_entry_t);

endpackage

// File: rtl/gpio_stream_packer_fifo.sv
// Parameterized synchronous FIFO with async active-low reset; pointers carry an
// extra MSB so full and empty are distinguishable when the index bits match.
module stream_fifo #(
   parameter int WIDTH = 36,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic             full_next_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign empty_o = (wr_q == rd_q);
   assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

   // A push into a full FIFO is allowed only when the head leaves in the same cycle.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   assign wr_d = do_push ? wr_q + (AW+1)'(1) : wr_q;
   assign rd_d = do_pop  ? rd_q + (AW+1)'(1) : rd_q;

   assign full_next_o = (wr_d[AW] != rd_d[AW]) && (wr_d[AW-1:0] == rd_d[AW-1:0]);
   assign head_data_o = mem_q[rd_q[AW-1:0]];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_q[AW-1:0]] <= push_data_i;
      end
   end

endmodule

// File: rtl/gpio_stream_packer.sv
// Packs 9-bit GPIO beats (byte + last flag) little-endian into 32-bit words and
// buffers them in a small FIFO ahead of the crossbar GPIO port.
module gpio_stream_packer
   import gpio_stream_packer_pkg::*;
#(
   parameter int DATA_W        = 32,
   parameter int GPIO_W        = 9,
   parameter int FIFO_DEPTH    = 2,
   parameter int FLUSH_TIMEOUT = 0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_stream_val,
   input  logic [GPIO_W-1:0] i_stream_data,
   output logic              i_stream_rdy,
   output logic              o_stream_val,
   output logic [DATA_W-1:0] o_stream_data,
   output logic              o_stream_last,
   input  logic              o_stream_rdy,
   output logic [2:0]        o_nbytes
);

   localparam int IDLE_W = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;
   localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(FLUSH_TIMEOUT);

   localparam logic [0:0] ST_EMPTY   = 1'b0;
   localparam logic [0:0] ST_PARTIAL = 1'b1;

   logic [1:0]             cnt_q, cnt_d;
   logic [DATA_W-1:0]      acc_q, acc_d;
   logic [IDLE_W-1:0]      idle_q, idle_d;
   logic                   rdy_q;
   logic [0:0]             state;

   logic [GPIO_BYTE_W-1:0] beat_byte;
   logic                   beat_last;
   logic                   accept, word_done, acc_push, timed_out, flush, push, pop;
   logic [DATA_W-1:0]      lane_word;
   fifo_entry_t            push_entry, head_entry;
   logic                   fifo_full, fifo_empty, fifo_full_next;

   assign state     = (cnt_q == 2'd0) ? ST_EMPTY : ST_PARTIAL;
   assign beat_byte = i_stream_data[GPIO_BYTE_W-1:0];
   assign beat_last = i_stream_data[GPIO_LAST_BIT];

   assign accept    = i_stream_val && rdy_q;
   assign lane_word = acc_q | ({{(DATA_W-GPIO_BYTE_W){1'b0}}, beat_byte} << {cnt_q, 3'b000});
   assign word_done = beat_last || (cnt_q == 2'(LANES - 1));
   assign acc_push  = accept && word_done;

   // An accept in the same cycle always beats the timeout flush.
   assign timed_out = (FLUSH_TIMEOUT > 0) && (state == ST_PARTIAL) && (idle_q == IDLE_LIMIT);
   assign flush     = timed_out && !accept && !fifo_full;
   assign push      = acc_push || flush;
   assign pop       = o_stream_val && o_stream_rdy;

   always_comb begin
      push_entry = '0;
      if (acc_push) begin
         push_entry.last   = beat_last;
         push_entry.nbytes = 3'(cnt_q) + 3'd1;
         push_entry.data   = lane_word;
      end else begin
         push_entry.last   = 1'b1;
         push_entry.nbytes = 3'(cnt_q);
         push_entry.data   = acc_q;
      end
   end

   always_comb begin
      cnt_d  = cnt_q;
      acc_d  = acc_q;
      idle_d = idle_q;
      if (accept) begin
         idle_d = '0;
         if (word_done) begin
            cnt_d = 2'd0;
            acc_d = '0;
         end else begin
            cnt_d = cnt_q + 2'd1;
            acc_d = lane_word;
         end
      end else if (flush) begin
         cnt_d  = 2'd0;
         acc_d  = '0;
         idle_d = '0;
      end else if (state == ST_PARTIAL) begin
         if ((FLUSH_TIMEOUT > 0) && (idle_q != IDLE_LIMIT)) begin
            idle_d = idle_q + IDLE_W'(1);
         end
      end else begin
         idle_d = '0;
      end
   end

   // Ready looks one cycle ahead at FIFO occupancy so it is never high while full.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q  <= 2'd0;
         acc_q  <= '0;
         idle_q <= '0;
         rdy_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         acc_q  <= acc_d;
         idle_q <= idle_d;
         rdy_q  <= !fifo_full_next;
      end
   end

   stream_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .reset_n     (reset_n),
      .push_i      (push),
      .push_data_i (push_entry),
      .pop_i       (pop),
      .head_data_o (head_entry),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .full_next_o (fifo_full_next)
   );

   assign i_stream_rdy  = rdy_q;
   assign o_stream_val  = !fifo_empty;
   assign o_stream_data = fifo_empty ? '0   : head_entry.data;
   assign o_stream_last = fifo_empty ? 1'b0 : head_entry.last;
   assign o_nbytes      = fifo_empty ? 3'd0 : head_entry.nbytes;

endmodule
